// File: rtl/pad_mux_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pad_mux_ctrl
// Purpose  : Pad multiplexer with per-pad output routing, per-input pad select,
//            2-flop synchronisers and debounce filters, plus a lockable config port.
// Revision : 1.0 - initial release
// ============================================================================
module pad_mux_ctrl #(
    parameter int NPads     = 70,
    parameter int NMioOut   = 32,
    parameter int NMioIn    = 32,
    parameter int DebounceW = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cfg_req_i,
    input  logic                 cfg_we_i,
    input  logic [7:0]           cfg_addr_i,
    input  logic [31:0]          cfg_wdata_i,
    output logic                 cfg_rvalid_o,
    output logic [31:0]          cfg_rdata_o,
    output logic                 cfg_err_o,
    input  logic [NMioOut-1:0]   periph_out_i,
    input  logic [NMioOut-1:0]   periph_oe_i,
    output logic [NMioIn-1:0]    periph_in_o,
    input  logic [NPads-1:0]     pad_in_i,
    output logic [NPads-1:0]     pad_out_o,
    output logic [NPads-1:0]     pad_oe_o
);

    localparam int c_OSW = $clog2(NMioOut + 1);
    localparam int c_ISW = $clog2(NPads + 1);
    localparam int c_OIW = $clog2(NPads);
    localparam int c_IIW = $clog2(NMioIn);
    localparam logic [7:0] c_ADDR_DBNC = 8'hC0;
    localparam logic [7:0] c_ADDR_LOCK = 8'hC1;

    logic [c_OSW-1:0]     r_outsel [NPads];
    logic [c_ISW-1:0]     r_insel  [NMioIn];
    logic [DebounceW-1:0] r_dbnc;
    logic                 r_lock;
    logic [DebounceW-1:0] r_cnt    [NMioIn];
    logic [NMioIn-1:0]    r_sync1;
    logic [NMioIn-1:0]    r_sync2;
    logic [NMioIn-1:0]    r_filt;
    logic [NPads-1:0]     r_pad_out;
    logic [NPads-1:0]     r_pad_oe;
    logic                 r_rvalid;
    logic                 r_err;
    logic [31:0]          r_rdata;

    logic                 w_hit_out;
    logic                 w_hit_in;
    logic                 w_hit_dbnc;
    logic                 w_hit_lock;
    logic                 w_err;
    logic                 w_wr;
    logic [c_OIW-1:0]     w_oidx;
    logic [c_IIW-1:0]     w_iidx;
    logic [31:0]          w_rdata;
    logic [NMioIn-1:0]    w_mux;
    logic [NMioIn-1:0]    w_clr;
    logic [NMioOut:0]     w_pout_ext;
    logic [NMioOut:0]     w_poe_ext;
    logic [NPads:0]       w_pin_ext;

    assign w_hit_out  = (32'(cfg_addr_i) < NPads);
    assign w_hit_in   = (cfg_addr_i[7:6] == 2'b10) && (32'(cfg_addr_i[5:0]) < NMioIn);
    assign w_hit_dbnc = (cfg_addr_i == c_ADDR_DBNC);
    assign w_hit_lock = (cfg_addr_i == c_ADDR_LOCK);
    assign w_oidx     = cfg_addr_i[c_OIW-1:0];
    assign w_iidx     = cfg_addr_i[c_IIW-1:0];

    // Unmapped, out-of-range select value, or any non-LOCK write while locked.
    assign w_err = !(w_hit_out || w_hit_in || w_hit_dbnc || w_hit_lock)
                 || (cfg_we_i && w_hit_out && (cfg_wdata_i > 32'(NMioOut)))
                 || (cfg_we_i && w_hit_in  && (cfg_wdata_i > 32'(NPads)))
                 || (cfg_we_i && r_lock && !w_hit_lock);
    assign w_wr  = cfg_req_i && cfg_we_i && !w_err;

    always_comb begin
        w_rdata = '0;
        if (!cfg_we_i && !w_err) begin
            if (w_hit_out)       w_rdata = 32'(r_outsel[w_oidx]);
            else if (w_hit_in)   w_rdata = 32'(r_insel[w_iidx]);
            else if (w_hit_dbnc) w_rdata = 32'(r_dbnc);
            else if (w_hit_lock) w_rdata = {31'd0, r_lock};
        end
    end

    // Select value 0 maps onto the constant-zero bit 0 of each extended vector.
    assign w_pout_ext = {periph_out_i, 1'b0};
    assign w_poe_ext  = {periph_oe_i, 1'b0};
    assign w_pin_ext  = {pad_in_i, 1'b0};

    always_comb begin
        w_mux = '0;
        w_clr = '0;
        for (int i = 0; i < NMioIn; i++) begin
            w_mux[i] = w_pin_ext[r_insel[i]];
            w_clr[i] = w_wr && (w_hit_dbnc || (w_hit_in && (32'(w_iidx) == i)));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int p = 0; p < NPads; p++) r_outsel[p] <= '0;
            for (int i = 0; i < NMioIn; i++) r_insel[i] <= '0;
            r_dbnc <= '0;
            r_lock <= 1'b0;
        end else if (w_wr) begin
            if (w_hit_out)  r_outsel[w_oidx] <= cfg_wdata_i[c_OSW-1:0];
            if (w_hit_in)   r_insel[w_iidx]  <= cfg_wdata_i[c_ISW-1:0];
            if (w_hit_dbnc) r_dbnc           <= cfg_wdata_i[DebounceW-1:0];
            if (w_hit_lock && cfg_wdata_i[0]) r_lock <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= cfg_req_i;
            r_err    <= cfg_req_i && w_err;
            r_rdata  <= cfg_req_i ? w_rdata : 32'd0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pad_out <= '0;
            r_pad_oe  <= '0;
        end else begin
            for (int p = 0; p < NPads; p++) begin
                r_pad_out[p] <= w_pout_ext[r_outsel[p]];
                r_pad_oe[p]  <= w_poe_ext[r_outsel[p]];
            end
        end
    end

    // A config clear takes precedence over a pending filter update.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_filt  <= '0;
            for (int i = 0; i < NMioIn; i++) r_cnt[i] <= '0;
        end else begin
            r_sync1 <= w_mux;
            r_sync2 <= r_sync1;
            for (int i = 0; i < NMioIn; i++) begin
                if (w_clr[i] || (r_sync2[i] == r_filt[i])) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == r_dbnc) begin
                    r_filt[i] <= r_sync2[i];
                    r_cnt[i]  <= '0;
                end else if (r_cnt[i] != {DebounceW{1'b1}}) begin
                    r_cnt[i] <= r_cnt[i] + DebounceW'(1);
                end
            end
        end
    end

    assign cfg_rvalid_o = r_rvalid;
    assign cfg_rdata_o  = r_rdata;
    assign cfg_err_o    = r_err;
    assign pad_out_o    = r_pad_out;
    assign pad_oe_o     = r_pad_oe;
    assign periph_in_o  = r_filt;

endmodule
`default_nettype wire

// File: tb/tb_pad_mux_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pad_mux_ctrl
// Purpose  : Self-checking bench for pad_mux_ctrl with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pad_mux_ctrl;
    localparam int NP = 70;
    localparam int NO = 32;
    localparam int NI = 32;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req = 1'b0;
    logic          we = 1'b0;
    logic [7:0]    addr = '0;
    logic [31:0]   wdata = '0;
    logic          rvalid;
    logic [31:0]   rdata;
    logic          err;
    logic [NO-1:0] pout = '0;
    logic [NO-1:0] poe = '0;
    logic [NI-1:0] pin;
    logic [NP-1:0] pad_in = '0;
    logic [NP-1:0] pad_out;
    logic [NP-1:0] pad_oe;

    int checks = 0;
    int errors = 0;

    // Behavioural model: register contents, pipeline samples, debounce start time.
    int          m_outsel [NP];
    int          m_insel  [NI];
    int          m_dbnc;
    bit          m_lock;
    bit          m_s1 [NI];
    bit          m_s2 [NI];
    bit          m_filt [NI];
    longint      m_start [NI];
    longint      cyc = 0;
    logic [NP-1:0] e_pad_out;
    logic [NP-1:0] e_pad_oe;
    logic [NI-1:0] e_pin;
    bit            e_rvalid;
    bit            e_err;
    logic [31:0]   e_rdata;

    pad_mux_ctrl #(.NPads(NP), .NMioOut(NO), .NMioIn(NI), .DebounceW(DW)) dut (
        .clk_i(clk), .rst_i(rst),
        .cfg_req_i(req), .cfg_we_i(we), .cfg_addr_i(addr), .cfg_wdata_i(wdata),
        .cfg_rvalid_o(rvalid), .cfg_rdata_o(rdata), .cfg_err_o(err),
        .periph_out_i(pout), .periph_oe_i(poe), .periph_in_o(pin),
        .pad_in_i(pad_in), .pad_out_o(pad_out), .pad_oe_o(pad_oe)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int p = 0; p < NP; p++) m_outsel[p] = 0;
        for (int i = 0; i < NI; i++) begin
            m_insel[i] = 0; m_s1[i] = 0; m_s2[i] = 0; m_filt[i] = 0; m_start[i] = -1;
        end
        m_dbnc = 0; m_lock = 0;
        e_pad_out = '0; e_pad_oe = '0; e_pin = '0;
        e_rvalid = 0; e_err = 0; e_rdata = '0;
    endtask

    // Advance one clock; the model predicts what the outputs show after the edge.
    task automatic tick();
        int a;
        bit bad, wr, mux;
        bit clr [NI];
        logic [31:0] rd;
        if (rst) begin
            model_reset();
        end else begin
            for (int p = 0; p < NP; p++) begin
                e_pad_out[p] = (m_outsel[p] == 0) ? 1'b0 : pout[m_outsel[p]-1];
                e_pad_oe[p]  = (m_outsel[p] == 0) ? 1'b0 : poe[m_outsel[p]-1];
            end
            a = int'(addr); rd = '0; bad = 0; wr = 0;
            for (int i = 0; i < NI; i++) clr[i] = 0;
            if (req) begin
                bad = !((a < NP) || (a >= 128 && a < 128 + NI) || a == 192 || a == 193);
                if (we && a < NP && wdata > 32'(NO)) bad = 1;
                if (we && a >= 128 && a < 128 + NI && wdata > 32'(NP)) bad = 1;
                if (we && m_lock && a != 193) bad = 1;
                if (!bad && !we)
                    rd = (a < NP) ? 32'(m_outsel[a]) : (a < 192) ? 32'(m_insel[a-128]) :
                         (a == 192) ? 32'(m_dbnc) : 32'(m_lock);
                wr = !bad && we;
                for (int i = 0; i < NI; i++) clr[i] = wr && (a == 192 || a == 128 + i);
            end
            for (int i = 0; i < NI; i++) begin
                mux = (m_insel[i] == 0) ? 1'b0 : pad_in[m_insel[i]-1];
                if (clr[i] || m_s2[i] == m_filt[i]) begin
                    m_start[i] = -1;
                end else begin
                    if (m_start[i] < 0) m_start[i] = cyc;
                    if (cyc - m_start[i] >= longint'(m_dbnc)) begin
                        m_filt[i] = m_s2[i]; m_start[i] = -1;
                    end
                end
                m_s2[i] = m_s1[i];
                m_s1[i] = mux;
                e_pin[i] = m_filt[i];
            end
            if (wr) begin
                if (a < NP) m_outsel[a] = int'(wdata);
                else if (a < 192) m_insel[a-128] = int'(wdata);
                else if (a == 192) m_dbnc = int'(wdata[7:0]);
                else if (wdata[0]) m_lock = 1;
            end
            e_rvalid = req; e_err = req && bad; e_rdata = rd;
            cyc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input bit w, input int a, input logic [31:0] d, output logic [33:0] resp);
        req = 1'b1; we = w; addr = 8'(a); wdata = d;
        tick();
        resp = {rvalid, err, rdata};
        req = 1'b0; we = 1'b0;
    endtask

    task automatic test_reset();
        logic [NP-1:0] junk;
        rst = 1'b1; req = 1'b1; we = 1'b0; addr = 8'hC0;
        junk = {$urandom, $urandom, $urandom};
        pad_in = junk; pout = $urandom; poe = $urandom;
        tick(); tick();
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %b want 0", rvalid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", err); end
        checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL rst_rdata got %h want 0", rdata); end
        checks++; if (pad_out !== '0 || pad_oe !== '0) begin errors++; $display("FAIL rst_pad got %h/%h want 0/0", pad_out, pad_oe); end
        checks++; if (pin !== '0) begin errors++; $display("FAIL rst_pin got %h want 0", pin); end
        rst = 1'b0; req = 1'b0; pad_in = '0;
        tick();
        checks++; if (pad_out !== '0 || pin !== '0) begin errors++; $display("FAIL post_rst got %h/%h want 0/0", pad_out, pin); end
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rst_discard got rvalid=%b want 0", rvalid); end
    endtask

    task automatic test_outsel();
        logic [33:0]   r;
        logic [NP-1:0] want;
        pout = '0; poe = '0;
        cfg(1, 5, 3, r);
        checks++; if (r !== {2'b10, 32'd0}) begin errors++; $display("FAIL wr_outsel5 got %h want %h", r, {2'b10, 32'd0}); end
        pout[2] = 1'b1; poe[2] = 1'b1;
        tick();
        want = '0; want[5] = 1'b1;
        checks++; if (pad_out !== want || pad_oe !== want) begin errors++; $display("FAIL route5 got %h/%h want %h", pad_out, pad_oe, want); end
        pout[2] = 1'b0;
        tick();
        checks++; if (pad_out !== '0 || pad_oe !== want) begin errors++; $display("FAIL route5_fall got %h/%h want 0/%h", pad_out, pad_oe, want); end
        cfg(0, 5, 0, r);
        checks++; if (r !== {2'b10, 32'd3}) begin errors++; $display("FAIL rd_outsel5 got %h want %h", r, {2'b10, 32'd3}); end
        poe = '0;
    endtask

    task automatic test_insel_latency();
        logic [33:0] r;
        int lat;
        cfg(1, 8'hC0, 0, r);
        cfg(1, 8'h80, 11, r);
        checks++; if (r !== {2'b10, 32'd0}) begin errors++; $display("FAIL wr_insel0 got %h want %h", r, {2'b10, 32'd0}); end
        pad_in = '0;
        tick(); tick(); tick();
        checks++; if (pin[0] !== 1'b0) begin errors++; $display("FAIL insel0_idle got %b want 0", pin[0]); end
        pad_in[10] = 1'b1; lat = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (pin[0] === 1'b1 && lat == 0) lat = k;
        end
        checks++; if (lat != 3) begin errors++; $display("FAIL insel_latency got %0d want 3", lat); end
    endtask

    task automatic test_debounce();
        logic [33:0] r;
        bit seen;
        int lat;
        pad_in = '0;
        cfg(1, 8'hC0, 4, r);
        cfg(1, 8'h81, 1, r);
        for (int k = 0; k < 6; k++) tick();
        pad_in[0] = 1'b1;
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            if (k == 3) pad_in[0] = 1'b0;
            tick();
            if (pin[1] !== 1'b0) seen = 1;
        end
        checks++; if (seen) begin errors++; $display("FAIL glitch3 got rise want no rise"); end
        pad_in[0] = 1'b1; lat = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (pin[1] === 1'b1 && lat == 0) lat = k;
        end
        checks++; if (lat != 7) begin errors++; $display("FAIL debounce_latency got %0d want 7", lat); end
    endtask

    task automatic test_errors();
        logic [33:0] r;
        cfg(1, 0, 1, r);
        cfg(1, 0, NO + 1, r);
        checks++; if (r !== {2'b11, 32'd0}) begin errors++; $display("FAIL outsel_range got %h want %h", r, {2'b11, 32'd0}); end
        cfg(0, 0, 0, r);
        checks++; if (r !== {2'b10, 32'd1}) begin errors++; $display("FAIL outsel_kept got %h want %h", r, {2'b10, 32'd1}); end
        cfg(1, 0, NO, r);
        checks++; if (r !== {2'b10, 32'd0}) begin errors++; $display("FAIL outsel_max got %h want %h", r, {2'b10, 32'd0}); end
        cfg(0, 8'hC5, 0, r);
        checks++; if (r !== {2'b11, 32'd0}) begin errors++; $display("FAIL rd_unmapped got %h want %h", r, {2'b11, 32'd0}); end
        cfg(1, 8'h82, NP + 1, r);
        checks++; if (r !== {2'b11, 32'd0}) begin errors++; $display("FAIL insel_range got %h want %h", r, {2'b11, 32'd0}); end
        cfg(1, 8'h82, NP, r);
        checks++; if (r !== {2'b10, 32'd0}) begin errors++; $display("FAIL insel_max got %h want %h", r, {2'b10, 32'd0}); end
        cfg(0, 8'h80 + NI, 0, r);
        checks++; if (r !== {2'b11, 32'd0}) begin errors++; $display("FAIL insel_beyond got %h want %h", r, {2'b11, 32'd0}); end
        cfg(0, 8'hC0, 0, r);
        checks++; if (r !== {2'b10, 32'd4}) begin errors++; $display("FAIL rd_dbnc got %h want %h", r, {2'b10, 32'd4}); end
    endtask

    task automatic test_lock();
        logic [33:0] r;
        cfg(1, 8'hC1, 1, r);
        checks++; if (r !== {2'b10, 32'd0}) begin errors++; $display("FAIL wr_lock got %h want %h", r, {2'b10, 32'd0}); end
        cfg(1, 2, 1, r);
        checks++; if (r !== {2'b11, 32'd0}) begin errors++; $display("FAIL locked_wr got %h want %h", r, {2'b11, 32'd0}); end
        cfg(0, 2, 0, r);
        checks++; if (r !== {2'b10, 32'd0}) begin errors++; $display("FAIL locked_rd got %h want %h", r, {2'b10, 32'd0}); end
        cfg(1, 8'hC1, 0, r);
        cfg(0, 8'hC1, 0, r);
        checks++; if (r !== {2'b10, 32'd1}) begin errors++; $display("FAIL lock_sticky got %h want %h", r, {2'b10, 32'd1}); end
        rst = 1'b1; tick(); rst = 1'b0;
        cfg(0, 8'hC1, 0, r);
        checks++; if (r !== {2'b10, 32'd0}) begin errors++; $display("FAIL lock_cleared got %h want %h", r, {2'b10, 32'd0}); end
        cfg(1, 2, 1, r);
        cfg(0, 2, 0, r);
        checks++; if (r !== {2'b10, 32'd1}) begin errors++; $display("FAIL unlocked_wr got %h want %h", r, {2'b10, 32'd1}); end
    endtask

    task automatic test_back_to_back();
        int sel;
        for (int c = 0; c < 2000; c++) begin
            pout = $urandom; poe = $urandom;
            if ($urandom_range(1, 0) == 1) pad_in[$urandom_range(NP-1, 0)] ^= 1'b1;
            req = ($urandom_range(9, 0) < 7); we = 1'($urandom_range(1, 0));
            sel = $urandom_range(9, 0);
            if (sel < 4)      begin addr = 8'($urandom_range(NP-1, 0)); wdata = $urandom_range(NO+2, 0); end
            else if (sel < 7) begin addr = 8'(128 + $urandom_range(NI-1, 0)); wdata = $urandom_range(NP+2, 0); end
            else if (sel == 7) begin addr = 8'hC0; wdata = $urandom_range(3, 0); end
            else if (sel == 8) begin addr = 8'hC1; wdata = 0; end
            else begin addr = 8'($urandom_range(255, 0)); wdata = $urandom; end
            if (addr == 8'hC1) wdata[0] = 1'b0;
            tick();
            checks++; if (pad_out !== e_pad_out || pad_oe !== e_pad_oe) begin errors++; $display("FAIL rnd_pad c=%0d got %h/%h want %h/%h", c, pad_out, pad_oe, e_pad_out, e_pad_oe); end
            checks++; if (pin !== e_pin) begin errors++; $display("FAIL rnd_pin c=%0d got %h want %h", c, pin, e_pin); end
            checks++; if (rvalid !== e_rvalid) begin errors++; $display("FAIL rnd_rvalid c=%0d got %b want %b", c, rvalid, e_rvalid); end
            if (e_rvalid) begin
                checks++; if ({err, rdata} !== {e_err, e_rdata}) begin errors++; $display("FAIL rnd_resp c=%0d got %b/%h want %b/%h", c, err, rdata, e_err, e_rdata); end
            end
        end
        req = 1'b0; we = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [33:0] r;
        pad_in = '0; pout = '1; poe = '1;
        cfg(1, 8'hC0, 6, r);
        cfg(1, 8'h83, 5, r);
        cfg(1, 1, 1, r);
        for (int k = 0; k < 8; k++) tick();
        pad_in[4] = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        req = 1'b1; we = 1'b0; addr = 8'hC0;
        tick();
        checks++; if ({rvalid, err, rdata} !== {2'b10, 32'd6}) begin errors++; $display("FAIL b2b_first got %h want %h", {rvalid, err, rdata}, {2'b10, 32'd6}); end
        rst = 1'b1;
        tick();
        checks++; if (rvalid !== 1'b0 || err !== 1'b0 || rdata !== 32'd0) begin errors++; $display("FAIL mid_rst_resp got %b/%b/%h want 0/0/0", rvalid, err, rdata); end
        checks++; if (pad_out !== '0 || pad_oe !== '0 || pin !== '0) begin errors++; $display("FAIL mid_rst_out got %h/%h/%h want 0", pad_out, pad_oe, pin); end
        rst = 1'b0; req = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        checks++; if (pin !== e_pin || pin[3] !== 1'b0) begin errors++; $display("FAIL mid_rst_abort got %h want %h", pin, e_pin); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_outsel();
        test_insel_latency();
        test_debounce();
        test_errors();
        test_lock();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/pad_mux_ctrl.md
PAD_MUX_CTRL -- requirements
Module: pad_mux_ctrl

Interface
REQ-001 The block SHALL have parameter NPads, default 70, giving the number of pads (max 128).
REQ-002 The block SHALL have parameter NMioOut, default 32, giving the number of peripheral output/enable pairs.
REQ-003 The block SHALL have parameter NMioIn, default 32, giving the number of peripheral inputs (max 64).
REQ-004 The block SHALL have parameter DebounceW, default 8, giving the debounce threshold and counter width.
REQ-005 The block SHALL have port clk_i, input, width 1, the single clock.
REQ-006 The block SHALL have port rst_i, input, width 1, a synchronous active-high reset.
REQ-007 The block SHALL have port cfg_req_i, input, width 1, the config access request.
REQ-008 The block SHALL have port cfg_we_i, input, width 1, where 1 = write.
REQ-009 The block SHALL have port cfg_addr_i, input, width 8, the register index.
REQ-010 The block SHALL have port cfg_wdata_i, input, width 32, the write data.
REQ-011 The block SHALL have port cfg_rvalid_o, output, width 1, the response strobe.
REQ-012 The block SHALL have port cfg_rdata_o, output, width 32, the read data.
REQ-013 The block SHALL have port cfg_err_o, output, width 1, the response error flag.
REQ-014 The block SHALL have ports periph_out_i and periph_oe_i, inputs, width NMioOut each, the peripheral drive value and enable.
REQ-015 The block SHALL have port periph_in_o, output, width NMioIn, the filtered peripheral inputs.
REQ-016 The block SHALL have port pad_in_i, input, width NPads, the raw pad input values.
REQ-017 The block SHALL have ports pad_out_o and pad_oe_o, outputs, width NPads each, the pad drive value and enable.

Function
REQ-018 Register map SHALL be: OUTSEL[p] at addr p (p<NPads); INSEL[i] at 0x80+i (i<NMioIn); DBNC at 0xC0 (bits DebounceW-1:0); LOCK at 0xC1 (bit0); unused bits read 0.
REQ-019 OUTSEL value 0 SHALL give out=0, oe=0; value k+1 SHALL route periph_out_i[k]/periph_oe_i[k]; legal range 0..NMioOut.
REQ-020 INSEL value 0 SHALL give constant 0; value p+1 SHALL select pad_in_i[p]; legal range 0..NPads.
REQ-021 Every cfg_req_i cycle SHALL be accepted, with no backpressure.
REQ-022 cfg_rvalid_o SHALL pulse exactly one cycle after each request, with cfg_rdata_o/cfg_err_o valid in that cycle.
REQ-023 Back-to-back requests SHALL each produce a response.
REQ-024 cfg_err_o SHALL assert, with no state change, for: an unmapped address; write data above the legal select range; or any write other than to LOCK while LOCK=1.
REQ-025 An erroring read SHALL return cfg_rdata_o=0.
REQ-026 A LOCK write with bit0=1 SHALL set LOCK; writing 0 SHALL have no effect; only rst_i SHALL clear LOCK.
REQ-027 A register write SHALL take effect on the clock edge ending the request cycle.
REQ-028 pad_out_o/pad_oe_o SHALL be registered, reflecting periph_*_i and OUTSEL one cycle later.
REQ-029 Input path per i SHALL be: mux, then 2-flop synchroniser, then debounce filter register driving periph_in_o[i].
REQ-030 With DBNC=0, the filter SHALL copy the synchroniser output each cycle, giving pad-to-periph_in_o latency of 3 cycles.
REQ-031 With DBNC=N>0, each per-input counter SHALL increment while sync != filtered.
REQ-032 Each per-input counter SHALL clear when sync == filtered.
REQ-033 When a counter equals N, filtered SHALL take the sync value and the counter SHALL clear, giving latency 3+N cycles for a stable edge.
REQ-034 A glitch shorter than N cycles SHALL be suppressed.
REQ-035 The counter SHALL saturate at its maximum (2^DebounceW - 1) and never wrap.
REQ-036 A write to INSEL[i] SHALL clear counter i while leaving filtered[i] unchanged.
REQ-037 A write to DBNC SHALL clear all counters.
REQ-038 A config write coincident with a filter update SHALL see the register write take priority for counter clearing.

Reset
REQ-039 While rst_i=1 at a clock edge, all registers SHALL reset: OUTSEL=0, INSEL=0, DBNC=0, LOCK=0, counters=0, synchronisers=0, filters=0.
REQ-040 After reset, outputs SHALL be pad_out_o=0, pad_oe_o=0, periph_in_o=0, cfg_rvalid_o=0, cfg_rdata_o=0, cfg_err_o=0.
REQ-041 A request in the same cycle as rst_i=1 SHALL be discarded with no response.
REQ-042 Reset mid-debounce SHALL abort the count.

Verification
REQ-043 Write OUTSEL[5]=3, drive periph_out_i[2]=1 and periph_oe_i[2]=1 -> pad_out_o[5]=1 and pad_oe_o[5]=1 one cycle later; all other pads stay 0.
REQ-044 Write INSEL[0]=11 with DBNC=0, then toggle pad_in_i[10] 0->1 -> periph_in_o[0]=1 exactly 3 cycles later.
REQ-045 Set DBNC=4, INSEL[1]=1, pulse pad_in_i[0] high for 3 cycles -> periph_in_o[1] stays 0; hold it high for 10 cycles -> it rises 7 cycles after the edge.
REQ-046 Write OUTSEL[0]=NMioOut+1 -> cfg_err_o=1 with the value unchanged; read address 0xC5 -> cfg_err_o=1 and cfg_rdata_o=0.
REQ-047 Write LOCK=1, then OUTSEL[2]=1 -> cfg_err_o=1 and readback 0; assert rst_i -> LOCK=0 and the write then succeeds.
REQ-048 Assert rst_i during an active debounce count with back-to-back reads in flight -> all outputs 0 next cycle and no cfg_rvalid_o for the dropped request.
